baccarat_controller: RTL

Round sequencer for the baccarat datapath. Drives the six card-load enables of the player/dealer hand registers and reads back the two hand scores (mod-10, face cards worth 0) plus the player's third card. Applies the natural / third-card rules and lights the win indicators. Sits between the card-dealing datapath (card source, hand registers, score units) and the board LEDs.

---
 rtl/baccarat_pkg.sv | 29 ++
 rtl/baccarat_controller_if.sv | 42 ++++
 rtl/baccarat_controller_banker_draw_rule.sv | 26 ++
 rtl/baccarat_controller.sv | 100 ++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat round sequencer: the FSM state set, card code
// constants and the card-code to point-value mapping.
package baccarat_pkg;

  typedef enum logic [3:0] {
    CLEAR,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL,
    DRAW_P3,
    EVAL_D,
    DRAW_D3,
    DONE
  } state_e;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_TEN  = 4'd10;
  localparam logic [3:0] CARD_K    = 4'd13;

  // Ten and face cards count zero; an empty slot also counts zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code == CARD_NONE || (code >= CARD_TEN && code <= CARD_K))
      return 4'd0;
    return code;
  endfunction

endpackage

// File: rtl/baccarat_controller_if.sv
// Control/status bundle between the round sequencer and the card datapath/LEDs.
// With BACCARAT_STATS_EN defined it also carries the per-outcome round counters.
interface baccarat_controller_if;
  logic       new_round;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       clear_hands;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
`ifdef BACCARAT_STATS_EN
  logic [7:0] player_wins;
  logic [7:0] dealer_wins;
  logic [7:0] ties;
`endif

  modport master (
    input  new_round, pscore, dscore, pcard3,
    output clear_hands, load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
`ifdef BACCARAT_STATS_EN
    , output player_wins, dealer_wins, ties
`endif
  );

  modport slave (
    output new_round, pscore, dscore, pcard3,
    input  clear_hands, load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
`ifdef BACCARAT_STATS_EN
    , input player_wins, dealer_wins, ties
`endif
  );
endinterface

// File: rtl/baccarat_controller_banker_draw_rule.sv
// Banker third-card decision: given the banker's two-card score and the
// player's third card, decides whether the banker draws.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore_i,
  input  logic [3:0] pcard3_i,
  output logic       draw_o
);

  logic [3:0] v;

  always_comb begin
    v      = card_value(pcard3_i);
    draw_o = 1'b0;
    case (dscore_i)
      4'd0, 4'd1, 4'd2: draw_o = 1'b1;
      4'd3:             draw_o = (v != 4'd8);
      4'd4:             draw_o = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw_o = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw_o = (v >= 4'd6) && (v <= 4'd7);
      default:          draw_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_controller.sv
// Baccarat round sequencer: Moore FSM stepping the deal, natural/third-card
// rules and win lights. Optional round counters under BACCARAT_STATS_EN.
module baccarat_controller
  import baccarat_pkg::*;
(
  input  logic                  slow_clock,
  input  logic                  reset,
  baccarat_controller_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   banker_draw;

  banker_draw_rule u_banker_rule (
    .dscore_i (bus.dscore),
    .pcard3_i (bus.pcard3),
    .draw_o   (banker_draw)
  );

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   state_d = DEAL_P1;
      DEAL_P1: state_d = DEAL_D1;
      DEAL_D1: state_d = DEAL_P2;
      DEAL_P2: state_d = DEAL_D2;
      DEAL_D2: state_d = EVAL;
      EVAL: begin
        if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) state_d = DONE;
        else if (bus.pscore <= 4'd5)                   state_d = DRAW_P3;
        else if (bus.dscore <= 4'd5)                   state_d = DRAW_D3;
        else                                           state_d = DONE;
      end
      DRAW_P3: state_d = EVAL_D;
      EVAL_D:  state_d = banker_draw ? DRAW_D3 : DONE;
      DRAW_D3: state_d = DONE;
      DONE:    state_d = bus.new_round ? CLEAR : DONE;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs decode from the state only, except the lights which also follow the live scores.
  always_comb begin
    bus.clear_hands      = (state_q == CLEAR);
    bus.load_pcard1      = (state_q == DEAL_P1);
    bus.load_dcard1      = (state_q == DEAL_D1);
    bus.load_pcard2      = (state_q == DEAL_P2);
    bus.load_dcard2      = (state_q == DEAL_D2);
    bus.load_pcard3      = (state_q == DRAW_P3);
    bus.load_dcard3      = (state_q == DRAW_D3);
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    if (state_q == DONE) begin
      bus.player_win_light = (bus.pscore >= bus.dscore);
      bus.dealer_win_light = (bus.dscore >= bus.pscore);
    end
  end

`ifdef BACCARAT_STATS_EN
  logic       was_done_q;
  logic [7:0] player_wins_q;
  logic [7:0] dealer_wins_q;
  logic [7:0] ties_q;
  logic       first_done;

  assign first_done = (state_q == DONE) && !was_done_q;

  // Counters only clear on reset, so they survive CLEAR between rounds.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      was_done_q    <= 1'b0;
      player_wins_q <= 8'd0;
      dealer_wins_q <= 8'd0;
      ties_q        <= 8'd0;
    end else begin
      was_done_q <= (state_q == DONE);
      if (first_done) begin
        if (bus.pscore > bus.dscore) begin
          if (player_wins_q != 8'hFF) player_wins_q <= player_wins_q + 8'd1;
        end else if (bus.dscore > bus.pscore) begin
          if (dealer_wins_q != 8'hFF) dealer_wins_q <= dealer_wins_q + 8'd1;
        end else begin
          if (ties_q != 8'hFF) ties_q <= ties_q + 8'd1;
        end
      end
    end
  end

  assign bus.player_wins = player_wins_q;
  assign bus.dealer_wins = dealer_wins_q;
  assign bus.ties        = ties_q;
`endif

endmodule
